// File: rtl/tcp_rx_parser_if.sv
// Segment byte stream from the IP receive stage into the TCP header parser.
// Two bytes per beat, [15:8] first on the wire; no backpressure.
interface tcp_rx_parser_if;
    logic        data_v_i;
    logic        data_start_i;
    logic [15:0] data_i;
    logic        data_last_i;
    logic        data_keep_i;
    logic        cancel_i;

    modport master (
        output data_v_i, data_start_i, data_i, data_last_i, data_keep_i, cancel_i
    );

    modport slave (
        input  data_v_i, data_start_i, data_i, data_last_i, data_keep_i, cancel_i
    );
endinterface

// File: rtl/tcp_rx_parser.sv
// Receive-side TCP header parser. Pulls seq/ack/flags/source port out of the
// header, skips options, counts payload bytes and presents one registered
// pulse per well-formed segment addressed to local_port_i. Everything else
// (foreign port, bad data offset, truncated, cancelled) is dropped silently.
module tcp_rx_parser #(
    parameter int SEQ_W  = 32,
    parameter int SIZE_W = 16,
    parameter int FLAG_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       local_port_i,
    tcp_rx_parser_if.slave    rx,
    output logic              rec_v_o,
    output logic [SIZE_W-1:0] rec_size_o,
    output logic [SEQ_W-1:0]  rec_seq_o,
    output logic [SEQ_W-1:0]  rec_ack_o,
    output logic [FLAG_W-1:0] rec_flag_o,
    output logic [15:0]       src_port_o
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        OPT,
        PAY,
        DROP
    } state_t;

    state_t state, state_next, drop_to;
    logic   accept;

    // cnt holds the header index of the beat currently on the bus.
    logic [4:0]        cnt;
    logic [4:0]        hdr_last;
    logic [15:0]       port_q;
    logic [3:0]        off_q;
    logic [15:0]       src_sh;
    logic [SEQ_W-1:0]  seq_sh;
    logic [SEQ_W-1:0]  ack_sh;
    logic [FLAG_W-1:0] flag_sh;
    logic [SIZE_W-1:0] size_sh;

    logic [FLAG_W-1:0] flag_rev;
    logic [SIZE_W:0]   size_sum_wide;
    logic [SIZE_W-1:0] size_sum;

    assign hdr_last = {off_q, 1'b0} - 5'd1;

    // Wire flags arrive CWR..FIN in bits 7..0; the socket wants CWR at index 0.
    always_comb begin
        flag_rev = '0;
        for (int i = 0; i < FLAG_W; i++) begin
            flag_rev[i] = rx.data_i[FLAG_W-1-i];
        end
    end

    // Payload accumulator with saturation; a short last beat carries one byte.
    always_comb begin
        size_sum_wide = {1'b0, size_sh}
                      + ((rx.data_last_i && !rx.data_keep_i) ? (SIZE_W+1)'(1) : (SIZE_W+1)'(2));
        size_sum      = size_sum_wide[SIZE_W] ? '1 : size_sum_wide[SIZE_W-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and accept decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_next = state;
        accept     = 1'b0;
        drop_to    = rx.data_last_i ? IDLE : DROP;

        if (rx.data_v_i && rx.data_start_i) begin
            // A start beat always begins a fresh segment, abandoning any other.
            if (rx.data_last_i)   state_next = IDLE;
            else if (rx.cancel_i) state_next = DROP;
            else                  state_next = HDR;
        end else if (rx.cancel_i && (state == HDR || state == OPT || state == PAY)) begin
            // Cancel may arrive on an idle cycle; then the last beat is still ahead.
            state_next = rx.data_v_i ? drop_to : DROP;
        end else if (rx.data_v_i) begin
            unique case (state)
                IDLE: ;
                HDR: begin
                    if (cnt == 5'd1 && rx.data_i != port_q) begin
                        state_next = drop_to;
                    end else if (cnt == 5'd6 && rx.data_i[15:12] < 4'd5) begin
                        state_next = drop_to;
                    end else if (cnt == 5'd9) begin
                        if (rx.data_last_i) begin
                            // Only an option-less header may end exactly here.
                            accept     = (off_q == 4'd5);
                            state_next = IDLE;
                        end else begin
                            state_next = (off_q > 4'd5) ? OPT : PAY;
                        end
                    end else if (rx.data_last_i) begin
                        state_next = IDLE;
                    end
                end
                OPT: begin
                    if (cnt == hdr_last) begin
                        accept     = rx.data_last_i;
                        state_next = rx.data_last_i ? IDLE : PAY;
                    end else if (rx.data_last_i) begin
                        state_next = IDLE;
                    end
                end
                PAY: begin
                    if (rx.data_last_i) begin
                        accept     = 1'b1;
                        state_next = IDLE;
                    end
                end
                DROP: begin
                    if (rx.data_last_i) state_next = IDLE;
                end
            endcase
        end
    end

    // Header capture into shadow registers and publish on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: shadow fields are reset too, so a pulse after reset never
            // exposes stale fields from an aborted segment.
            cnt        <= '0;
            port_q     <= '0;
            off_q      <= '0;
            src_sh     <= '0;
            seq_sh     <= '0;
            ack_sh     <= '0;
            flag_sh    <= '0;
            size_sh    <= '0;
            rec_v_o    <= 1'b0;
            rec_size_o <= '0;
            rec_seq_o  <= '0;
            rec_ack_o  <= '0;
            rec_flag_o <= '0;
            src_port_o <= '0;
        end else begin
            rec_v_o <= accept;
            if (accept) begin
                rec_size_o <= (state == PAY) ? size_sum : size_sh;
                rec_seq_o  <= seq_sh;
                rec_ack_o  <= ack_sh;
                rec_flag_o <= flag_sh;
                src_port_o <= src_sh;
            end

            if (rx.data_v_i) begin
                if (rx.data_start_i) begin
                    cnt     <= 5'd1;
                    port_q  <= local_port_i;
                    src_sh  <= rx.data_i;
                    size_sh <= '0;
                end else if (state == HDR || state == OPT) begin
                    cnt <= cnt + 5'd1;
                    if (state == HDR) begin
                        case (cnt)
                            5'd2:    seq_sh[SEQ_W-1:16] <= rx.data_i;
                            5'd3:    seq_sh[15:0]       <= rx.data_i;
                            5'd4:    ack_sh[SEQ_W-1:16] <= rx.data_i;
                            5'd5:    ack_sh[15:0]       <= rx.data_i;
                            5'd6: begin
                                off_q   <= rx.data_i[15:12];
                                flag_sh <= flag_rev;
                            end
                            default: ;
                        endcase
                    end
                end else if (state == PAY) begin
                    size_sh <= size_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_tcp_rx_parser.sv
// Randomized bench for tcp_rx_parser. Segments are built as beat lists from
// their header fields; the expected verdict and fields come from the segment
// description (port match, offset, length, cancel) using plain arithmetic.
module tb_tcp_rx_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] local_port;
    logic        rec_v;
    logic [15:0] rec_size;
    logic [31:0] rec_seq;
    logic [31:0] rec_ack;
    logic [7:0]  rec_flag;
    logic [15:0] src_port;

    tcp_rx_parser_if rx ();

    tcp_rx_parser dut (
        .clk          (clk),
        .reset        (reset),
        .local_port_i (local_port),
        .rx           (rx),
        .rec_v_o      (rec_v),
        .rec_size_o   (rec_size),
        .rec_seq_o    (rec_seq),
        .rec_ack_o    (rec_ack),
        .rec_flag_o   (rec_flag),
        .src_port_o   (src_port)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_cnt = 0;
    int pulse_cyc = -1;
    int last_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every high sample counts, so a stretched pulse shows up as an extra one.
    always @(negedge clk) begin
        if (rec_v === 1'b1) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
    end

    // Reference state: outputs expected to be held and pulses expected so far.
    int          exp_pulses = 0;
    logic [15:0] exp_size, exp_src;
    logic [31:0] exp_seq, exp_ack;
    logic [7:0]  exp_flag;

    logic [15:0] beats[$];
    bit          last_keep;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_beat();
        @(posedge clk); #1;
        rx.data_v_i     = 1'b0;
        rx.data_start_i = 1'($urandom);
        rx.data_i       = 16'($urandom);
        rx.data_last_i  = 1'($urandom);
        rx.data_keep_i  = 1'($urandom);
        rx.cancel_i     = 1'b0;
    endtask

    task automatic build_seg(input logic [15:0] src, input logic [15:0] dst,
                             input logic [31:0] seq, input logic [31:0] ack,
                             input int off, input logic [7:0] wf, input int n_pay);
        beats.delete();
        beats.push_back(src);
        beats.push_back(dst);
        beats.push_back(seq[31:16]);
        beats.push_back(seq[15:0]);
        beats.push_back(ack[31:16]);
        beats.push_back(ack[15:0]);
        beats.push_back({4'(off), 4'($urandom), wf});
        for (int i = 7; i < 10; i++) beats.push_back(16'($urandom));
        for (int i = 10; i < 2 * off; i++) beats.push_back(16'($urandom));
        for (int i = 0; i < (n_pay + 1) / 2; i++) beats.push_back(16'($urandom));
        last_keep = (n_pay % 2 == 0);
    endtask

    task automatic drive_seg(input int n, input bit do_last, input int cancel_at, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(99) < gap_pct) begin
                repeat ($urandom_range(1, 3)) idle_beat();
            end
            @(posedge clk); #1;
            rx.data_v_i     = 1'b1;
            rx.data_start_i = (i == 0);
            rx.data_i       = beats[i];
            rx.data_last_i  = do_last && (i == n - 1);
            rx.data_keep_i  = (i == n - 1 && n == beats.size()) ? last_keep : 1'b1;
            rx.cancel_i     = (i == cancel_at);
            last_cyc        = cyc;
        end
    endtask

    task automatic check_outputs(input string name, input bit acc);
        check({name, ".pulses"}, 64'(pulse_cnt), 64'(exp_pulses));
        if (acc) check({name, ".latency"}, 64'(pulse_cyc), 64'(last_cyc + 1));
        check({name, ".size"}, rec_size, exp_size);
        check({name, ".seq"},  rec_seq,  exp_seq);
        check({name, ".ack"},  rec_ack,  exp_ack);
        check({name, ".flag"}, rec_flag, exp_flag);
        check({name, ".src"},  src_port, exp_src);
    endtask

    // trunc > 0 cuts the segment to that many beats; cancel_at < 0 means none.
    task automatic run_case(input string name, input logic [15:0] src, input logic [15:0] dst,
                            input logic [31:0] seq, input logic [31:0] ack, input int off,
                            input logic [7:0] wf, input int n_pay, input int trunc,
                            input int cancel_at, input bit do_last, input int gap_pct,
                            input bit settle);
        int n;
        int bytes;
        bit acc;
        build_seg(src, dst, seq, ack, off, wf, n_pay);
        n   = (trunc > 0 && trunc < beats.size()) ? trunc : beats.size();
        acc = do_last && (dst == local_port) && (off >= 5)
              && !(cancel_at >= 0 && cancel_at < n) && (n >= 2 * off);
        if (acc) begin
            bytes = (n - 2 * off) * 2;
            if (n == beats.size() && !last_keep) bytes--;
            exp_size = (bytes > 65535) ? 16'hFFFF : 16'(bytes);
            exp_seq  = seq;
            exp_ack  = ack;
            exp_src  = src;
            for (int i = 0; i < 8; i++) exp_flag[i] = wf[7 - i];
            exp_pulses++;
        end
        drive_seg(n, do_last, cancel_at, gap_pct);
        if (settle) begin
            repeat (3) idle_beat();
            check_outputs(name, acc);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset       = 1'b1;
        rx.data_v_i = 1'b0;
        rx.cancel_i = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b0;
        exp_size = '0;
        exp_seq  = '0;
        exp_ack  = '0;
        exp_flag = '0;
        exp_src  = '0;
        check("reset.rec_v", rec_v, 1'b0);
        check("reset.size",  rec_size, exp_size);
        check("reset.seq",   rec_seq,  exp_seq);
        check("reset.ack",   rec_ack,  exp_ack);
        check("reset.flag",  rec_flag, exp_flag);
        check("reset.src",   src_port, exp_src);
    endtask

    int          r_off, r_pay, r_trunc, r_cancel;
    logic [15:0] r_dst;

    initial begin
        reset           = 1'b1;
        local_port      = 16'h0050;
        rx.data_v_i     = 1'b0;
        rx.data_start_i = 1'b0;
        rx.data_i       = '0;
        rx.data_last_i  = 1'b0;
        rx.data_keep_i  = 1'b0;
        rx.cancel_i     = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // SYN+ACK, no options, ends on the final header beat.
        run_case("synack", 16'hC001, 16'h0050, 32'h1000_0000, 32'h0000_0001,
                 5, 8'h12, 0, 0, -1, 1, 0, 1);
        check("synack.flag_lit", rec_flag, 8'h48);

        // Options are skipped; odd payload with valid gaps.
        run_case("opts", 16'h1111, 16'h0050, 32'hDEAD_BEEF, 32'h0BAD_F00D,
                 8, 8'h18, 5, 0, -1, 1, 50, 1);

        // Foreign destination port.
        local_port = 16'h1235;
        run_case("port", 16'h2222, 16'h1234, 32'h1, 32'h2, 5, 8'h10, 4, 0, -1, 1, 0, 1);

        // Cancel on the last beat, then a last beat at header index 7.
        local_port = 16'h0050;
        run_case("cancel", 16'h3333, 16'h0050, 32'h3, 32'h4, 5, 8'h10, 6, 0, 12, 1, 0, 1);
        run_case("trunc7", 16'h4444, 16'h0050, 32'h5, 32'h6, 5, 8'h10, 6, 8, -1, 1, 0, 1);
        run_case("good",   16'h5555, 16'h0050, 32'h7, 32'h8, 6, 8'h11, 3, 0, -1, 1, 20, 1);

        // Segment A abandoned by a start beat at its payload beat 3; B completes.
        run_case("abandon_a", 16'h6666, 16'h0050, 32'hA, 32'hA, 5, 8'h08, 20, 13, -1, 0, 0, 1);
        run_case("abandon_b", 16'h7777, 16'h0050, 32'hB, 32'hB, 5, 8'h01, 7, 0, -1, 1, 0, 1);

        // Reset in the middle of a header, stray non-start beats, then a full segment.
        run_case("rst_mid", 16'h8888, 16'h0050, 32'hC, 32'hC, 5, 8'h02, 4, 5, -1, 0, 0, 0);
        do_reset();
        repeat (4) begin
            @(posedge clk); #1;
            rx.data_v_i     = 1'b1;
            rx.data_start_i = 1'b0;
            rx.data_i       = 16'($urandom);
            rx.data_last_i  = 1'($urandom);
            rx.data_keep_i  = 1'b1;
        end
        run_case("after_rst", 16'h9999, 16'h0050, 32'hCAFE_0001, 32'hCAFE_0002,
                 7, 8'h29, 9, 0, -1, 1, 30, 1);

        // Back-to-back segments: start beat right after a last beat.
        run_case("b2b_1", 16'hAAAA, 16'h0050, 32'h11, 32'h12, 5, 8'h10, 2, 0, -1, 1, 0, 0);
        run_case("b2b_2", 16'hBBBB, 16'h0050, 32'h21, 32'h22, 5, 8'h18, 3, 0, -1, 1, 0, 1);

        // Payload byte count saturates.
        run_case("sat", 16'hCCCC, 16'h0050, 32'h31, 32'h32, 5, 8'h10, 65537, 0, -1, 1, 0, 1);

        // Random segments.
        for (int k = 0; k < 60; k++) begin
            r_off      = ($urandom_range(9) == 0) ? int'($urandom_range(0, 4))
                                                  : int'($urandom_range(5, 15));
            local_port = 16'($urandom);
            r_dst      = ($urandom_range(4) == 0) ? (local_port ^ 16'($urandom_range(1, 65535)))
                                                  : local_port;
            r_pay      = $urandom_range(0, 40);
            r_trunc    = ($urandom_range(5) == 0) ? int'($urandom_range(1, 40)) : 0;
            r_cancel   = ($urandom_range(6) == 0) ? int'($urandom_range(0, 60)) : -1;
            run_case("rand", 16'($urandom), r_dst, $urandom, $urandom, r_off,
                     8'($urandom), r_pay, r_trunc, r_cancel, 1, 30, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
